// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit-FIFO block. Holds
//               the transmitter and receiver state encodings, the 8N1 frame
//               constants and the default bit period.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // System clocks per serial bit when the instantiating design does not
    // override it (868 suits 100 MHz / 115200 baud).
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // 8N1 frame constants.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Byte-wide synchronous FIFO with first-word fall-through head
//               output. Writes while full are dropped; a simultaneous read
//               and write leave the occupancy unchanged.
// Revision    : 1.0 - initial release
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset (empties the FIFO)
//               wr_en    - enqueue wr_data this cycle
//               wr_data  - byte to enqueue
//               rd_en    - pop the head byte this cycle
//               rd_data  - current head byte (valid while !empty)
//               full     - FIFO holds FIFO_DEPTH bytes
//               empty    - FIFO holds no bytes
//               cnt      - current occupancy
// ============================================================================
module uart_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full    = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (r_cnt == '0);
    assign cnt     = r_cnt;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_txfifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_txfifo
// Description : 8N1 UART with a transmit FIFO and an optional receiver.
//               Bytes written into the FIFO are sent back to back on tx.
//               Define UART_RX_EN to build the receiver; without it the
//               receive outputs are tied low and rx is ignored.
// Revision    : 1.0 - initial release
// Ports       : clk             - system clock, rising edge
//               rst             - asynchronous active-low reset
//               fifo_in/fifo_wr - byte and enqueue strobe
//               fifo_full/fifo_empty/fifo_cnt - FIFO status
//               tx              - serial output, idle high
//               is_transmitting - frame in progress (pop to end of stop bit)
//               rx              - asynchronous serial input
//               received        - one-cycle pulse, rx_byte holds a new byte
//               rx_byte         - last good received byte
//               is_receiving    - receive frame in progress
//               recv_error      - one-cycle pulse on bad start/stop bit
// ============================================================================
module uart_txfifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  fifo_in,
    input  logic                        fifo_wr,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        tx,
    output logic                        is_transmitting,
    input  logic                        rx,
    output logic                        received,
    output logic [7:0]                  rx_byte,
    output logic                        is_receiving,
    output logic                        recv_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_data_last = BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic       w_fifo_rd;
    logic [7:0] w_fifo_head;

    uart_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_in),
        .rd_en   (w_fifo_rd),
        .rd_data (w_fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .cnt     (fifo_cnt)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state, w_tx_state_nx;
    logic [CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nx;
    logic [BIT_W-1:0] r_tx_bit,   w_tx_bit_nx;
    logic [7:0]       r_tx_shift, w_tx_shift_nx;
    logic             w_tx_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
        end
    end

    assign w_tx_last = (r_tx_cnt == c_bit_last);

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_fifo_rd     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    w_fifo_rd     = 1'b1;
                    w_tx_shift_nx = w_fifo_head;
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_DATA;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == c_data_last) begin
                        w_tx_state_nx = TX_STOP;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx = '0;
                    // Chain straight into the next frame when data waits,
                    // so consecutive frames have no idle gap.
                    if (!fifo_empty) begin
                        w_fifo_rd     = 1'b1;
                        w_tx_shift_nx = w_fifo_head;
                        w_tx_state_nx = TX_START;
                    end else begin
                        w_tx_state_nx = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    // Decoded from registered state only, so reset forces tx high at once.
    always_comb begin
        tx = STOP_BIT;
        case (r_tx_state)
            TX_START: tx = START_BIT;
            TX_DATA:  tx = r_tx_shift[r_tx_bit];
            default:  tx = STOP_BIT;
        endcase
    end

    assign is_transmitting = (r_tx_state != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
`ifdef UART_RX_EN
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        r_rx_state, w_rx_state_nx;
    logic [CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nx;
    logic [BIT_W-1:0] r_rx_bit,   w_rx_bit_nx;
    logic [7:0]       r_rx_shift, w_rx_shift_nx;
    logic [7:0]       r_rx_byte,  w_rx_byte_nx;
    logic             r_received, w_received_nx;
    logic             r_recv_error, w_recv_error_nx;
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic             w_rx_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Synchronizer resets to the idle line level to avoid a
            // false start after reset.
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_rx_state   <= w_rx_state_nx;
            r_rx_cnt     <= w_rx_cnt_nx;
            r_rx_bit     <= w_rx_bit_nx;
            r_rx_shift   <= w_rx_shift_nx;
            r_rx_byte    <= w_rx_byte_nx;
            r_received   <= w_received_nx;
            r_recv_error <= w_recv_error_nx;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // The fall is seen on cycle 0 of the start bit; cycle 0 of RX_START is
    // bit cycle 1, so the start sample lands at CLKS_PER_BIT/2 and every
    // later sample one full bit after the previous one.
    always_comb begin
        w_rx_state_nx   = r_rx_state;
        w_rx_cnt_nx     = r_rx_cnt;
        w_rx_bit_nx     = r_rx_bit;
        w_rx_shift_nx   = r_rx_shift;
        w_rx_byte_nx    = r_rx_byte;
        w_received_nx   = 1'b0;
        w_recv_error_nx = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nx = '0;
                    if (r_rx_sync != START_BIT) begin
                        w_recv_error_nx = 1'b1;
                        w_rx_state_nx   = RX_IDLE;
                    end else begin
                        w_rx_bit_nx   = '0;
                        w_rx_state_nx = RX_DATA;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == c_data_last) begin
                        w_rx_state_nx = RX_STOP;
                    end else begin
                        w_rx_bit_nx = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_IDLE;
                    if (r_rx_sync == STOP_BIT) begin
                        w_rx_byte_nx  = r_rx_shift;
                        w_received_nx = 1'b1;
                    end else begin
                        w_recv_error_nx = 1'b1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    assign received     = r_received;
    assign recv_error   = r_recv_error;
    assign rx_byte      = r_rx_byte;
    assign is_receiving = (r_rx_state != RX_IDLE);
`else
    logic w_rx_unused;
    assign w_rx_unused  = rx;
    assign received     = 1'b0;
    assign recv_error   = 1'b0;
    assign rx_byte      = 8'h00;
    assign is_receiving = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_txfifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_txfifo
// Description : Directed self-checking bench for uart_txfifo with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4. Receiver scenarios are
//               compiled when UART_RX_EN is defined; otherwise the tied-off
//               receive outputs are checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txfifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic [7:0] fifo_in = 8'h00;
    logic       fifo_wr = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       lb      = 1'b0;
    logic       rx;

    logic       fifo_full, fifo_empty, tx, is_transmitting;
    logic [2:0] fifo_cnt;
    logic       received, is_receiving, recv_error;
    logic [7:0] rx_byte;

    assign rx = lb ? tx : rx_drv;

    uart_txfifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_in         (fifo_in),
        .fifo_wr         (fifo_wr),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_cnt        (fifo_cnt),
        .tx              (tx),
        .is_transmitting (is_transmitting),
        .rx              (rx),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_receiving    (is_receiving),
        .recv_error      (recv_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse/level counters sampled on the falling edge.
    int rcv_cnt   = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int rxing_cnt = 0;
    always @(negedge clk) begin
        if (received)               rcv_cnt++;
        if (recv_error)             err_cnt++;
        if (received && recv_error) both_cnt++;
        if (is_receiving)           rxing_cnt++;
    end

    // Independent 8N1 decoder on tx: the first falling-edge sample showing
    // tx low is start-bit cycle 0; data/stop are sampled at mid-bit.
    logic [7:0] q_bytes[$];
    logic       q_stops[$];
    initial begin : mon_tx
        logic [7:0] b;
        logic       s;
        b = 8'h00;
        s = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && tx == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                s = tx;
                q_bytes.push_back(b);
                q_stops.push_back(s);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_in = b;
        fifo_wr = 1'b1;
        @(negedge clk);
        fifo_wr = 1'b0;
    endtask

    task automatic wait_tx_done(input int budget);
        int i;
        i = 0;
        while ((is_transmitting || !fifo_empty) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("tx_done_in_budget", (i < budget), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin : main
        int lat;
        int hi;
        int i;
        int sz;
        int r0, e0, x0;
        logic saw_full;
        int exp_cnt[6];

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_cnt",        fifo_cnt, 0);
        check("rst_full",       fifo_full, 0);
        check("rst_empty",      fifo_empty, 1);
        check("rst_tx",         tx, 1);
        check("rst_is_tx",      is_transmitting, 0);
        check("rst_received",   received, 0);
        check("rst_recv_error", recv_error, 0);
        check("rst_is_rx",      is_receiving, 0);
        check("rst_rx_byte",    rx_byte, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- single byte 0xA5 ----------------
        q_bytes.delete();
        q_stops.delete();
        push_byte(8'hA5);
        lat = -1;
        hi  = 0;
        i   = 1;
        while (i < 200) begin
            if (tx == 1'b0 && lat < 0) lat = i;
            if (is_transmitting) hi++;
            else if (hi > 0) break;
            @(negedge clk);
            i++;
        end
        check("a5_start_latency_ok", (lat > 0 && lat <= 3), 1);
        check("a5_is_tx_cycles",     hi, 40);
        check("a5_empty_after",      fifo_empty, 1);
        check("a5_tx_idle_after",    tx, 1);
        repeat (4) @(negedge clk);
        sz = q_bytes.size();
        check("a5_frame_count", sz, 1);
        if (sz >= 1) begin
            check("a5_byte", q_bytes[0], 8'hA5);
            check("a5_stop", q_stops[0], 1);
        end

        // ---------------- overflow 0x01..0x06 ----------------
        // Head is popped one cycle after the first write, so occupancy runs
        // 1,1,2,3,4 and the sixth write is dropped while full.
        q_bytes.delete();
        q_stops.delete();
        exp_cnt  = '{1, 1, 2, 3, 4, 4};
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) begin
            fifo_in = 8'(k + 1);
            fifo_wr = 1'b1;
            @(negedge clk);
            if (fifo_full) saw_full = 1'b1;
            check($sformatf("ovf_cnt_%0d", k), fifo_cnt, exp_cnt[k]);
        end
        fifo_wr = 1'b0;
        check("ovf_saw_full", saw_full, 1);
        wait_tx_done(600);
        sz = q_bytes.size();
        check("ovf_frame_count_ok", (sz == 4 || sz == 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < sz) begin
                check($sformatf("ovf_byte_%0d", k), q_bytes[k], 8'(k + 1));
                check($sformatf("ovf_stop_%0d", k), q_stops[k], 1);
            end
        end

        // ---------------- reset mid-frame ----------------
        q_bytes.delete();
        q_stops.delete();
        push_byte(8'h5A);
        push_byte(8'h77);
        i = 0;
        while (!is_transmitting && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("mid_tx_started", is_transmitting, 1);
        repeat (10) @(negedge clk);
        check("mid_pre_cnt", fifo_cnt, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_tx",    tx, 1);
        check("mid_rst_cnt",   fifo_cnt, 0);
        check("mid_rst_is_tx", is_transmitting, 0);
        check("mid_rst_empty", fifo_empty, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_stays_idle", is_transmitting, 0);
        q_bytes.delete();
        q_stops.delete();
        push_byte(8'hC3);
        wait_tx_done(200);
        sz = q_bytes.size();
        check("resume_frame_count", sz, 1);
        if (sz >= 1) begin
            check("resume_byte", q_bytes[0], 8'hC3);
            check("resume_stop", q_stops[0], 1);
        end

`ifdef UART_RX_EN
        // ---------------- loopback 0x3C ----------------
        lb = 1'b1;
        r0 = rcv_cnt;
        e0 = err_cnt;
        push_byte(8'h3C);
        wait_tx_done(200);
        repeat (10) @(negedge clk);
        check("lb_received_pulses", rcv_cnt - r0, 1);
        check("lb_error_pulses",    err_cnt - e0, 0);
        check("lb_rx_byte",         rx_byte, 8'h3C);
        check("lb_rx_idle",         is_receiving, 0);
        lb = 1'b0;
        repeat (4) @(negedge clk);

        // ---------------- framing error ----------------
        r0 = rcv_cnt;
        e0 = err_cnt;
        drive_rx_frame(8'h99, 1'b0);
        repeat (10) @(negedge clk);
        check("fe_error_pulses",    err_cnt - e0, 1);
        check("fe_received_pulses", rcv_cnt - r0, 0);
        check("fe_rx_byte_kept",    rx_byte, 8'h3C);
        check("fe_rx_idle",         is_receiving, 0);

        // ---------------- one-cycle glitch ----------------
        r0 = rcv_cnt;
        e0 = err_cnt;
        x0 = rxing_cnt;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("gl_error_pulses",    err_cnt - e0, 1);
        check("gl_received_pulses", rcv_cnt - r0, 0);
        check("gl_saw_receiving",   (rxing_cnt > x0), 1);
        check("gl_rx_idle",         is_receiving, 0);
        check("gl_rx_byte_kept",    rx_byte, 8'h3C);
        check("never_both_pulses",  both_cnt, 0);
`else
        // ---------------- receiver absent ----------------
        rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        check("norx_received", rcv_cnt, 0);
        check("norx_error",    err_cnt, 0);
        check("norx_is_rx",    rxing_cnt, 0);
        check("norx_rx_byte",  rx_byte, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_txfifo.md
UART_TXFIFO -- requirements
Module: uart_txfifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clocks per serial bit (at least 4).
REQ-002 Parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, at least 2).
REQ-003 clk  in  1  system clock; all state is on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 fifo_in  in  8  byte to enqueue for transmit.
REQ-006 fifo_wr  in  1  enqueue strobe; one byte per asserted cycle.
REQ-007 fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 fifo_empty  out  1  FIFO holds 0 bytes.
REQ-009 fifo_cnt  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 tx  out  1  serial output, idle high.
REQ-011 is_transmitting  out  1  a frame is being shifted out.
REQ-012 rx  in  1  serial input, asynchronous.
REQ-013 received  out  1  one-cycle pulse when rx_byte holds a valid new byte.
REQ-014 rx_byte  out  8  last received byte.
REQ-015 is_receiving  out  1  a receive frame is in progress.
REQ-016 recv_error  out  1  one-cycle pulse on a bad start or stop bit.

Function
REQ-017 Frame format: 8N1, meaning 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit lasting CLKS_PER_BIT cycles.
REQ-018 The FIFO is first-in first-out.
REQ-019 A write while fifo_full is dropped.
REQ-020 On a simultaneous internal read and external write, fifo_cnt is unchanged and both operations take effect.
REQ-021 The pointers wrap modulo FIFO_DEPTH.
REQ-022 The transmit states are IDLE, START, DATA and STOP.
REQ-023 In IDLE, with fifo_empty=0, the transmitter pops the head byte and drives tx=0 within 2 cycles of the pop.
REQ-024 is_transmitting is high from the pop until the end of the stop bit.
REQ-025 Back-to-back frames are permitted with no extra idle time beyond the stop bit.
REQ-026 The receiver passes rx through a 2-flop synchronizer.
REQ-027 In receiver IDLE, a falling edge starts a frame and raises is_receiving.
REQ-028 The receiver samples rx at mid-bit (CLKS_PER_BIT/2) of the start bit; if rx is high there, the frame is aborted with a recv_error pulse.
REQ-029 Data bits are sampled at each mid-bit.
REQ-030 At the stop-bit mid-point: rx=1 updates rx_byte and pulses received; rx=0 pulses recv_error and leaves rx_byte unchanged.
REQ-031 The receiver returns to IDLE after the stop-bit mid-point.
REQ-032 received and recv_error are never high in the same cycle.

Reset
REQ-033 Asserting rst sets: FIFO empty, fifo_cnt=0, fifo_full=0, fifo_empty=1, tx=1, is_transmitting=0, is_receiving=0, received=0, recv_error=0, rx_byte=0, and both state machines to IDLE.
REQ-034 A reset asserted mid-frame aborts the frame immediately and discards FIFO contents.
REQ-035 Operation resumes on the first rising clk edge after rst deasserts.

Configuration
REQ-036 Macro UART_RX_EN compiled in: the receiver is present as specified.
REQ-037 Macro UART_RX_EN absent: there is no receiver logic; received, is_receiving and recv_error are tied to 0, rx_byte is tied to 0, and rx is ignored.

Structure
REQ-038 A shared package uart_pkg holds the TX and RX state enumerations, the frame constants START_BIT=0, STOP_BIT=1 and DATA_BITS=8, and the default CLKS_PER_BIT.
REQ-039 The FIFO is a sub-module named uart_fifo, parameterized by FIFO_DEPTH, instantiated once; the transmitter and receiver are inline.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-040 Single byte: write 0xA5 once -> tx emits 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; is_transmitting is high for 40 cycles; fifo_empty=1 afterwards.
REQ-041 Overflow: write 0x01..0x06 on consecutive cycles -> fifo_full asserts; the output order is 0x01, 0x02, 0x03, 0x04, plus at most one more byte accepted after the first pop; no byte is duplicated.
REQ-042 Loopback (UART_RX_EN defined, tx tied to rx): write 0x3C -> one received pulse with rx_byte=0x3C; recv_error stays 0.
REQ-043 Framing error: drive rx with a frame carrying stop=0 -> one recv_error pulse, no received pulse, and rx_byte keeps its prior value.
REQ-044 Glitch: drive rx low for 1 cycle -> recv_error pulses at the start-bit mid-point and the receiver returns to IDLE.
REQ-045 Reset mid-frame: assert rst during a DATA bit -> tx=1, fifo_cnt=0 and is_transmitting=0 immediately, before the next clk edge.
